// File: rtl/regfile_wb_arbiter.sv
// Purpose : shares the single register-file write port between two writeback sources.
//           s0 is the ALU/execute source and s1 is the load unit.
// Latency : a handshake at edge N drives rf_regWrite/rf_rd/rf_writeData during cycle N..N+1.
// Backpr. : each cycle, ready goes to at most one valid source. The loser holds its request.
//           The register file itself never stalls.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   s0_valid/s0_ready/s0_rd/s0_data   writeback source 0 (ALU)
//   s1_valid/s1_ready/s1_rd/s1_data   writeback source 1 (load unit)
//   rf_regWrite/rf_rd/rf_writeData    registered register-file write port
//   grant_src                  source of the most recent accepted write (registered)
//   busy                       both sources requesting this cycle (combinational)
//   conflict_cnt               saturating count of conflict cycles; present only when
//                              WB_CONFLICT_CNT_EN is defined
//
// Arbitration:
//   PRIORITY_MODE=0 selects round-robin between the two sources.
//   PRIORITY_MODE=1 gives s0 fixed priority. s1 is force-granted after MAX_WAIT
//   consecutive losing cycles.
module regfile_wb_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_rd,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_rd,
    input  logic [DATA_W-1:0] s1_data,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              grant_src,
    output logic              busy
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    // One writeback beat: destination index plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    // MAX_WAIT is limited to 1..15, so four bits cover the starvation counter.
    localparam int            CNT_W      = 4;
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    // State registers
    logic              rf_we_q,      rf_we_d;
    wb_t               rf_wb_q,      rf_wb_d;
    logic              grant_src_q,  grant_src_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    // Arbitration and transfer decode
    logic grant_s1;
    logic xfer0;
    logic xfer1;
    wb_t  wb_sel;

    assign busy = s0_valid && s1_valid;

    // Decide the grant. When only one source is valid, that source is granted.
    // When both are valid, the result depends on the arbitration mode.
    always_comb begin
        grant_s1 = 1'b0;
        if (s0_valid && s1_valid) begin
            if (PRIORITY_MODE == 0) begin
                // Alternate away from whichever source completed the last transfer.
                grant_s1 = ~last_grant_q;
            end else begin
                grant_s1 = (starve_cnt_q == MAX_WAIT_C);
            end
        end else begin
            grant_s1 = s1_valid;
        end
    end

    // Ready is forced low during reset so that no handshake can complete while the
    // output stage is being cleared.
    assign s0_ready = !rst && s0_valid && !grant_s1;
    assign s1_ready = !rst && s1_valid &&  grant_s1;

    assign xfer0 = s0_valid && s0_ready;
    assign xfer1 = s1_valid && s1_ready;

    // Output stage next-state logic
    always_comb begin
        wb_sel.rd    = s0_rd;
        wb_sel.data  = s0_data;
        rf_we_d      = 1'b0;
        rf_wb_d      = rf_wb_q;
        grant_src_d  = grant_src_q;
        last_grant_d = last_grant_q;

        if (xfer1) begin
            wb_sel.rd   = s1_rd;
            wb_sel.data = s1_data;
        end

        if (xfer0 || xfer1) begin
            // A write to x0 still completes the handshake and updates the staged
            // rd/data and grant_src, but the write enable stays low.
            rf_we_d      = (wb_sel.rd != '0);
            rf_wb_d      = wb_sel;
            grant_src_d  = xfer1;
            last_grant_d = xfer1;
        end
    end

    // Starvation counter. This counter is only meaningful in fixed-priority mode.
    always_comb begin
        starve_cnt_d = '0;
        if (PRIORITY_MODE != 0) begin
            if (!s1_valid || xfer1) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != MAX_WAIT_C) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end
    end

    // last_grant resets to 1 so that s0 wins the first round-robin conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q      <= 1'b0;
            rf_wb_q      <= '0;
            grant_src_q  <= 1'b0;
            last_grant_q <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_wb_q      <= rf_wb_d;
            grant_src_q  <= grant_src_d;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign rf_regWrite  = rf_we_q;
    assign rf_rd        = rf_wb_q.rd;
    assign rf_writeData = rf_wb_q.data;
    assign grant_src    = grant_src_q;

`ifdef WB_CONFLICT_CNT_EN
    // Saturating count of cycles in which both sources requested the write port.
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (busy && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
